cipher_capture_sequencer: RTL

//   Sequences one RPA capture run. Parses the UART RX byte stream into key and plaintext,

---
 rtl/cipher_capture_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cipher_capture_sequencer.sv
// Capture-run sequencer: parses UART command bytes into key/plaintext, launches the
// cipher core with a sensor trigger window around it, and streams the ciphertext back.
module cipher_capture_sequencer #(
  parameter int PT_BYTES  = 8,
  parameter int KEY_BYTES = 10,
  parameter int TIMEOUT   = 1024,
  parameter int TRIG_POST = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  output logic [KEY_BYTES*8-1:0] key,
  output logic [PT_BYTES*8-1:0]  pt,
  output logic                   cipher_start,
  input  logic                   cipher_done,
  input  logic [PT_BYTES*8-1:0]  ct,
  output logic                   trigger,
  output logic                   tx_start,
  output logic [7:0]             tx_byte,
  input  logic                   tx_busy,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int MAX_BYTES = (PT_BYTES > KEY_BYTES) ? PT_BYTES : KEY_BYTES;
  localparam int BCW       = $clog2(MAX_BYTES + 1);
  localparam int SHW       = MAX_BYTES * 8;
  localparam int CNT_MAX   = (TIMEOUT > TRIG_POST) ? TIMEOUT : TRIG_POST;
  localparam int CW        = $clog2(CNT_MAX);
  localparam int PTW       = PT_BYTES * 8;

  localparam logic [BCW-1:0] KEY_LAST  = BCW'(KEY_BYTES - 1);
  localparam logic [BCW-1:0] PT_LAST   = BCW'(PT_BYTES - 1);
  localparam logic [BCW-1:0] PT_COUNT  = BCW'(PT_BYTES);
  localparam logic [CW-1:0]  TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  POST_LAST = CW'(TRIG_POST - 1);

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_PT  = 8'h50;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_KEY  = 3'd1;
  localparam logic [2:0] S_LOAD_PT   = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_POST      = 3'd5;
  localparam logic [2:0] S_TX_SEND   = 3'd6;
  localparam logic [2:0] S_TX_WAIT   = 3'd7;

  logic [2:0]             state_q, state_d;
  logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SHW-9:0]         shadow_q, shadow_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic [PTW-1:0]         pt_q, pt_d;
  logic [PTW-1:0]         tx_sr_q, tx_sr_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_start_q, tx_start_d;
  logic                   cipher_start_q, cipher_start_d;
  logic                   trigger_q, trigger_d;
  logic                   busy_q, busy_d;
  logic                   err_timeout_q, err_timeout_d;
  logic [SHW-1:0]         shift_in;

  // Incoming bytes enter at the LSB end, so the first byte ends up as the MSB.
  assign shift_in = {shadow_q, rx_byte};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    key_d         = key_q;
    pt_d          = pt_q;
    tx_sr_d       = tx_sr_q;
    tx_byte_d     = tx_byte_q;
    tx_start_d    = 1'b0;
    err_timeout_d = err_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_KEY) begin
            state_d    = S_LOAD_KEY;
            byte_cnt_d = '0;
          end else if (rx_byte == CMD_PT) begin
            state_d       = S_LOAD_PT;
            byte_cnt_d    = '0;
            err_timeout_d = 1'b0;
          end
        end
      end
      S_LOAD_KEY: begin
        if (rx_valid) begin
          if (byte_cnt_q == KEY_LAST) begin
            key_d      = shift_in[KEY_BYTES*8-1:0];
            byte_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            shadow_d   = shift_in[SHW-9:0];
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      S_LOAD_PT: begin
        if (rx_valid) begin
          if (byte_cnt_q == PT_LAST) begin
            pt_d       = shift_in[PTW-1:0];
            byte_cnt_d = '0;
            state_d    = S_START;
          end else begin
            shadow_d   = shift_in[SHW-9:0];
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // A done strobe in the final timeout cycle still counts as a completed run.
        if (cipher_done) begin
          tx_sr_d    = ct;
          byte_cnt_d = PT_COUNT;
          cnt_d      = '0;
          state_d    = S_POST;
        end else if (cnt_q == TO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_POST: begin
        if (cnt_q == POST_LAST) begin
          state_d = S_TX_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_TX_SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_byte_d  = tx_sr_q[PTW-1 -: 8];
          state_d    = S_TX_WAIT;
        end
      end
      S_TX_WAIT: begin
        // The transmitter raises busy one cycle late, so the start cycle itself is skipped.
        if (!tx_start_q && !tx_busy) begin
          tx_sr_d    = {tx_sr_q[PTW-9:0], 8'h00};
          byte_cnt_d = byte_cnt_q - BCW'(1);
          state_d    = (byte_cnt_q == BCW'(1)) ? S_IDLE : S_TX_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cipher_start_d = (state_d == S_START);
    trigger_d      = (state_d == S_START) || (state_d == S_WAIT_DONE) || (state_d == S_POST);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= '0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      key_q          <= '0;
      pt_q           <= '0;
      tx_sr_q        <= '0;
      tx_byte_q      <= '0;
      tx_start_q     <= 1'b0;
      cipher_start_q <= 1'b0;
      trigger_q      <= 1'b0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop see pre-edge values, regardless of order.
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      key_q          <= key_d;
      pt_q           <= pt_d;
      tx_sr_q        <= tx_sr_d;
      tx_byte_q      <= tx_byte_d;
      tx_start_q     <= tx_start_d;
      cipher_start_q <= cipher_start_d;
      trigger_q      <= trigger_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign key          = key_q;
  assign pt           = pt_q;
  assign cipher_start = cipher_start_q;
  assign trigger      = trigger_q;
  assign tx_start     = tx_start_q;
  assign tx_byte      = tx_byte_q;
  assign busy         = busy_q;
  assign err_timeout  = err_timeout_q;

endmodule
